// File: rtl/ode_pkg.sv
// Shared definitions for the ODE solver blocks: memory map, Q7.8 limits, FSM states.
package ode_pkg;

    localparam int unsigned N_ADDR      = 0;
    localparam int unsigned HTEMP_ADDR  = 4;
    localparam int unsigned XPROC_BASE  = 6;
    localparam int unsigned XINIT_BASE  = 56;
    localparam int unsigned A_BASE      = 156;
    localparam int unsigned U_BASE      = 2656;

    localparam int unsigned       FRAC_BITS = 8;
    localparam logic signed [15:0] Q_MAX    = 16'sh7FFF;
    localparam logic signed [15:0] Q_MIN    = 16'sh8000;

    localparam int unsigned MAX_N = 50;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_H,
        S_ROW,
        S_RD_AX,
        S_MAC,
        S_RD_U,
        S_UPD,
        S_UPD_H,
        S_WR,
        S_DONE
    } state_e;

endpackage

// File: rtl/euler_update_if.sv
// Step-controller handshake plus shared-RAM ports of the Euler update engine.
interface euler_update_if #(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 64
);
    logic                     Euler_Enable;
    logic                     Euler_End;
    logic                     Euler_Error;
    logic                     Euler_Memory_WR_Enable;
    logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_A;
    logic [ADDRESS_WIDTH-1:0] RAM_Address_RD_B;
    logic [ADDRESS_WIDTH-1:0] RAM_Address_WR;
    logic [DATA_WIDTH-1:0]    RAM_Data_RD_A;
    logic [DATA_WIDTH-1:0]    RAM_Data_RD_B;
    logic [DATA_WIDTH-1:0]    RAM_Data_WR;

    // Engine side
    modport master (
        input  Euler_Enable, RAM_Data_RD_A, RAM_Data_RD_B,
        output Euler_End, Euler_Error, Euler_Memory_WR_Enable,
               RAM_Address_RD_A, RAM_Address_RD_B, RAM_Address_WR, RAM_Data_WR
    );

    // Step controller / RAM side
    modport slave (
        output Euler_Enable, RAM_Data_RD_A, RAM_Data_RD_B,
        input  Euler_End, Euler_Error, Euler_Memory_WR_Enable,
               RAM_Address_RD_A, RAM_Address_RD_B, RAM_Address_WR, RAM_Data_WR
    );
endinterface

// File: rtl/euler_fx_mac.sv
// Saturating Q7.8 multiply and add, each reporting its own overflow.
module euler_fx_mac
    import ode_pkg::*;
(
    input  logic signed [15:0] mul_a_i,
    input  logic signed [15:0] mul_b_i,
    input  logic signed [15:0] add_a_i,
    input  logic signed [15:0] add_b_i,
    output logic signed [15:0] prod_o,
    output logic               mul_ovf_o,
    output logic signed [15:0] sum_o,
    output logic               add_ovf_o
);

    logic signed [31:0] prod_full;
    logic signed [31:0] prod_shift;
    logic signed [16:0] sum_full;

    // Full product rescaled to Q7.8, clamped to the 16-bit range
    always_comb begin
        prod_full  = 32'(mul_a_i) * 32'(mul_b_i);
        prod_shift = prod_full >>> FRAC_BITS;
        prod_o     = prod_shift[15:0];
        mul_ovf_o  = 1'b0;
        if (prod_shift > 32'sd32767) begin
            prod_o    = Q_MAX;
            mul_ovf_o = 1'b1;
        end else if (prod_shift < -32'sd32768) begin
            prod_o    = Q_MIN;
            mul_ovf_o = 1'b1;
        end
    end

    // 17-bit sum; overflow when the two top bits disagree, clamp by true sign
    always_comb begin
        sum_full  = $signed({add_a_i[15], add_a_i}) + $signed({add_b_i[15], add_b_i});
        sum_o     = sum_full[15:0];
        add_ovf_o = sum_full[16] ^ sum_full[15];
        if (add_ovf_o) begin
            sum_o = sum_full[16] ? Q_MIN : Q_MAX;
        end
    end

endmodule

// File: rtl/euler_update.sv
// Forward-Euler update: X_process[i] = X_init[i] + h*(A[i]*X_init + U[i]) in Q7.8.
module euler_update
    import ode_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 64
) (
    input logic            CLK,
    input logic            RST,
    euler_update_if.master bus
);

    state_e                    state_q;
    logic [15:0]               n_q;
    logic signed [15:0]        h_q;
    logic [15:0]               i_q;
    logic [15:0]               j_q;
    logic signed [15:0]        acc_q;
    logic [ADDRESS_WIDTH-1:0]  a_ptr_q;
    logic [ADDRESS_WIDTH-1:0]  row_base_q;
    logic [ADDRESS_WIDTH-1:0]  rd_a_q;
    logic [ADDRESS_WIDTH-1:0]  rd_b_q;
    logic [ADDRESS_WIDTH-1:0]  wr_addr_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;
    logic                      wr_en_q;
    logic                      end_q;
    logic                      err_q;

    logic signed [15:0] rd_a_w;
    logic signed [15:0] rd_b_w;
    logic signed [15:0] mul_a;
    logic signed [15:0] mul_b;
    logic signed [15:0] add_a;
    logic signed [15:0] add_b;
    logic signed [15:0] prod_w;
    logic signed [15:0] sum_w;
    logic               mul_ovf;
    logic               add_ovf;
    logic               sat_hit;
    logic               unused_hi;

    assign rd_a_w    = $signed(bus.RAM_Data_RD_A[15:0]);
    assign rd_b_w    = $signed(bus.RAM_Data_RD_B[15:0]);
    assign unused_hi = ^{bus.RAM_Data_RD_A[DATA_WIDTH-1:16], bus.RAM_Data_RD_B[DATA_WIDTH-1:16]};

    // Multiplier operands: A*x while accumulating, h*acc during the scaling step
    always_comb begin
        mul_a = rd_a_w;
        mul_b = rd_b_w;
        if (state_q == S_UPD_H) begin
            mul_a = h_q;
            mul_b = acc_q;
        end
    end

    // Adder operands: acc+product, then acc+U, then x_i+scaled term
    always_comb begin
        add_a = acc_q;
        add_b = prod_w;
        if (state_q == S_UPD) begin
            add_b = rd_a_w;
        end else if (state_q == S_UPD_H) begin
            add_a = rd_b_w;
        end
    end

    // The multiplier is idle while folding in U, so its flag is ignored then
    assign sat_hit = (state_q == S_UPD) ? add_ovf : (mul_ovf | add_ovf);

    euler_fx_mac u_mac (
        .mul_a_i   (mul_a),
        .mul_b_i   (mul_b),
        .add_a_i   (add_a),
        .add_b_i   (add_b),
        .prod_o    (prod_w),
        .mul_ovf_o (mul_ovf),
        .sum_o     (sum_w),
        .add_ovf_o (add_ovf)
    );

    // Control FSM with registered RAM addresses, write port and status flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            h_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            acc_q      <= '0;
            a_ptr_q    <= '0;
            row_base_q <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            end_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (!bus.Euler_Enable && state_q != S_IDLE && state_q != S_DONE) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.Euler_Enable && !end_q) begin
                            err_q   <= 1'b0;
                            rd_a_q  <= ADDRESS_WIDTH'(N_ADDR);
                            rd_b_q  <= ADDRESS_WIDTH'(HTEMP_ADDR);
                            state_q <= S_LD_H;
                        end
                    end
                    S_LD_H: begin
                        n_q        <= bus.RAM_Data_RD_A[15:0];
                        h_q        <= rd_b_w;
                        i_q        <= '0;
                        row_base_q <= '0;
                        if (bus.RAM_Data_RD_A[15:0] == 16'd0) begin
                            state_q <= S_DONE;
                        end else if (bus.RAM_Data_RD_A[15:0] > 16'(MAX_N)) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ROW;
                        end
                    end
                    S_ROW: begin
                        acc_q   <= '0;
                        j_q     <= '0;
                        a_ptr_q <= ADDRESS_WIDTH'(A_BASE) + row_base_q;
                        state_q <= S_RD_AX;
                    end
                    S_RD_AX: begin
                        rd_a_q  <= a_ptr_q;
                        rd_b_q  <= ADDRESS_WIDTH'(XINIT_BASE) + ADDRESS_WIDTH'(j_q);
                        state_q <= S_MAC;
                    end
                    S_MAC: begin
                        acc_q   <= sum_w;
                        err_q   <= err_q | sat_hit;
                        j_q     <= j_q + 16'd1;
                        a_ptr_q <= a_ptr_q + ADDRESS_WIDTH'(1);
                        state_q <= (j_q + 16'd1 == n_q) ? S_RD_U : S_RD_AX;
                    end
                    S_RD_U: begin
                        rd_a_q  <= ADDRESS_WIDTH'(U_BASE) + ADDRESS_WIDTH'(i_q);
                        rd_b_q  <= ADDRESS_WIDTH'(XINIT_BASE) + ADDRESS_WIDTH'(i_q);
                        state_q <= S_UPD;
                    end
                    S_UPD: begin
                        acc_q   <= sum_w;
                        err_q   <= err_q | sat_hit;
                        state_q <= S_UPD_H;
                    end
                    S_UPD_H: begin
                        wr_addr_q <= ADDRESS_WIDTH'(XPROC_BASE) + ADDRESS_WIDTH'(i_q);
                        wr_data_q <= {{(DATA_WIDTH-16){sum_w[15]}}, sum_w};
                        wr_en_q   <= 1'b1;
                        err_q     <= err_q | sat_hit;
                        state_q   <= S_WR;
                    end
                    S_WR: begin
                        i_q        <= i_q + 16'd1;
                        row_base_q <= row_base_q + ADDRESS_WIDTH'(n_q);
                        state_q    <= (i_q + 16'd1 == n_q) ? S_DONE : S_ROW;
                    end
                    S_DONE: begin
                        if (bus.Euler_Enable) begin
                            end_q <= 1'b1;
                        end else begin
                            end_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.RAM_Address_RD_A       = rd_a_q;
    assign bus.RAM_Address_RD_B       = rd_b_q;
    assign bus.RAM_Address_WR         = wr_addr_q;
    assign bus.RAM_Data_WR            = wr_data_q;
    assign bus.Euler_Memory_WR_Enable = wr_en_q;
    assign bus.Euler_End              = end_q;
    assign bus.Euler_Error            = err_q;

endmodule

// File: tb/tb_euler_update.sv
// Bench for euler_update: directed systems, arithmetic reference model, write scoreboard.
module tb_euler_update;
    import ode_pkg::*;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 64;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    euler_update_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    euler_update #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign bus_if.RAM_Data_RD_A = mem[bus_if.RAM_Address_RD_A];
    assign bus_if.RAM_Data_RD_B = mem[bus_if.RAM_Address_RD_B];

    int  n_vec    = 0;
    int  n_bad    = 0;
    int  wr_count = 0;
    bit  prev_wr  = 1'b0;
    bit  m_err;
    int  exp_lat;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic longint rd(input int a);
        return longint'($signed(mem[a][15:0]));
    endfunction

    function automatic longint sat16(input longint v);
        if (v > 32767) begin
            m_err = 1'b1;
            return 32767;
        end
        if (v < -32768) begin
            m_err = 1'b1;
            return -32768;
        end
        return v;
    endfunction

    // Reference: evaluate the Euler step straight from RAM contents
    task automatic model_run();
        int     n;
        longint acc, h, t, r;
        exp_q.delete();
        m_err = 1'b0;
        n = int'(mem[N_ADDR][15:0]);
        h = rd(HTEMP_ADDR);
        if (n > int'(MAX_N)) begin
            m_err   = 1'b1;
            exp_lat = 3;
            return;
        end
        exp_lat = 3 + n * (2 * n + 5);
        for (int i = 0; i < n; i++) begin
            acc = 0;
            for (int j = 0; j < n; j++)
                acc = sat16(acc + sat16((rd(A_BASE + i * n + j) * rd(XINIT_BASE + j)) >>> 8));
            acc = sat16(acc + rd(U_BASE + i));
            t   = sat16((h * acc) >>> 8);
            r   = sat16(rd(XINIT_BASE + i) + t);
            exp_q.push_back('{addr: AW'(XPROC_BASE + i), data: r});
        end
    endtask

    task automatic setw(input int a, input logic [15:0] v);
        mem[a] = {{48{v[15]}}, v};
    endtask

    task automatic clear_map();
        for (int a = 0; a < 2706; a++) mem[a] = '0;
    endtask

    // Write scoreboard and RAM write port
    always @(negedge clk) begin
        if (bus_if.Euler_Memory_WR_Enable === 1'b1) begin
            wr_t e;
            bit  ok;
            ok = 1'b1;
            wr_count++;
            n_vec++;
            if (prev_wr) begin
                ok = 1'b0;
                $display("FAIL write_b2b: strobe high two cycles, addr %0d", bus_if.RAM_Address_WR);
            end
            if (exp_q.size() == 0) begin
                ok = 1'b0;
                $display("FAIL write_unexpected: got addr %0d data %h, expected none",
                         bus_if.RAM_Address_WR, bus_if.RAM_Data_WR);
            end else begin
                e = exp_q.pop_front();
                if (bus_if.RAM_Address_WR !== e.addr || bus_if.RAM_Data_WR !== e.data) begin
                    ok = 1'b0;
                    $display("FAIL write_data: got %0d:%h, expected %0d:%h",
                             bus_if.RAM_Address_WR, bus_if.RAM_Data_WR, e.addr, e.data);
                end
            end
            if (!ok) n_bad++;
            mem[bus_if.RAM_Address_WR] = bus_if.RAM_Data_WR;
        end
        prev_wr = (bus_if.Euler_Memory_WR_Enable === 1'b1);
    end

    task automatic run_case(input string tag);
        int cyc;
        int w0;
        int n_exp;
        model_run();
        n_exp = exp_q.size();
        w0    = wr_count;
        @(posedge clk); #1 bus_if.Euler_Enable = 1'b1;
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1)
                check({tag, "_first_rd"}, 64'({bus_if.RAM_Address_RD_A, bus_if.RAM_Address_RD_B}),
                      64'({13'd0, 13'd4}));
            if (bus_if.Euler_End === 1'b1) break;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_error"}, 64'(bus_if.Euler_Error), 64'(m_err));
        @(negedge clk); #1;
        check({tag, "_writes"}, 64'(wr_count - w0), 64'(n_exp));
        check({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
        bus_if.Euler_Enable = 1'b0;
        @(posedge clk); #1;
        check({tag, "_end_fall"}, 64'(bus_if.Euler_End), 64'(0));
    endtask

    task automatic setup_n2();
        clear_map();
        setw(0, 16'd2);     setw(4, 16'h0080);
        setw(156, 16'h0100); setw(157, 16'h0000);
        setw(158, 16'h0000); setw(159, 16'h0100);
        setw(2656, 16'h0100); setw(2657, 16'hFF00);
        setw(56, 16'h0100);  setw(57, 16'h0200);
    endtask

    initial begin
        int cyc;
        int w0;
        bit seen;
        bus_if.Euler_Enable = 1'b0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;

        // Asynchronous reset between edges
        #1 rst_n = 1'b0;
        #1;
        check("rst_ctrl", 64'({bus_if.RAM_Address_RD_A, bus_if.RAM_Address_RD_B, bus_if.RAM_Address_WR,
                               bus_if.Euler_Memory_WR_Enable, bus_if.Euler_End, bus_if.Euler_Error}), 64'(0));
        check("rst_data", bus_if.RAM_Data_WR, 64'(0));
        #20 rst_n = 1'b1;

        // N=1: 2.0 + 1.0*(0.5*2.0 + 0)
        clear_map();
        setw(0, 16'd1); setw(4, 16'h0100); setw(156, 16'h0080); setw(56, 16'h0200);
        model_run();
        check("n1_model", exp_q[0].data, 64'h0300);
        run_case("n1");
        check("n1_mem", mem[6], 64'h0300);

        // N=2: identity A, U=[1,-1], h=0.5, X=[1,2]
        setup_n2();
        model_run();
        check("n2_model0", exp_q[0].data, 64'h0200);
        check("n2_model1", exp_q[1].data, 64'h0280);
        run_case("n2");
        check("n2_mem6", mem[6], 64'h0200);
        check("n2_mem7", mem[7], 64'h0280);

        // Saturation: 100*100 overflows
        clear_map();
        setw(0, 16'd1); setw(4, 16'h0100); setw(156, 16'h6400); setw(56, 16'h6400);
        model_run();
        check("sat_model", exp_q[0].data, 64'h7FFF);
        check("sat_model_err", 64'(m_err), 64'(1));
        run_case("sat");
        check("sat_mem", mem[6], 64'h7FFF);

        // N=0 and N=51: no writes, sentinel at X_process[0] survives
        clear_map();
        setw(6, 16'hDEAD);
        run_case("n0");
        setw(0, 16'd51);
        run_case("n51");
        check("n51_sentinel", mem[6], 64'hFFFF_FFFF_FFFF_DEAD);

        // Abort after the first write of an N=3 run whose row 0 saturates
        clear_map();
        setw(0, 16'd3); setw(4, 16'h0100);
        setw(156, 16'h6400); setw(160, 16'h0100); setw(164, 16'h0100);
        setw(56, 16'h6400);  setw(57, 16'h0100);  setw(58, 16'hFF00);
        model_run();
        w0 = wr_count;
        @(posedge clk); #1 bus_if.Euler_Enable = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
            if (bus_if.Euler_Memory_WR_Enable === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_first_wr_seen", 64'(seen), 64'(1));
        bus_if.Euler_Enable = 1'b0;
        @(negedge clk); #1 exp_q.delete();
        repeat (6) @(posedge clk);
        #1;
        check("abort_writes", 64'(wr_count - w0), 64'(1));
        check("abort_rd_hold", 64'(bus_if.RAM_Address_RD_A), 64'(2656));
        check("abort_end_low", 64'(bus_if.Euler_End), 64'(0));
        check("abort_mem7", mem[7], 64'(0));

        // Restart with benign data: full run from row 0 with Error cleared
        setw(156, 16'h0080); setw(56, 16'h0100); setw(4, 16'h0080); setw(2657, 16'h0080);
        run_case("restart");
        check("xinit_kept", mem[58], 64'hFFFF_FFFF_FFFF_FF00);

        // Reset while accumulating row 0 of the N=2 system
        setup_n2();
        model_run();
        w0 = wr_count;
        @(posedge clk); #1 bus_if.Euler_Enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mr_in_row", 64'(bus_if.RAM_Address_RD_B), 64'(56));
        #2 rst_n = 1'b0;
        #1;
        check("mr_zero_ctrl", 64'({bus_if.RAM_Address_RD_A, bus_if.RAM_Address_RD_B, bus_if.RAM_Address_WR,
                                   bus_if.Euler_Memory_WR_Enable, bus_if.Euler_End, bus_if.Euler_Error}), 64'(0));
        check("mr_zero_data", bus_if.RAM_Data_WR, 64'(0));
        exp_q.delete();
        bus_if.Euler_Enable = 1'b0;
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mr_idle", 64'({bus_if.RAM_Address_RD_A, bus_if.RAM_Address_RD_B, bus_if.Euler_End}), 64'(0));
        check("mr_no_writes", 64'(wr_count - w0), 64'(0));
        run_case("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
